// File: rtl/mods.sv
// Baseband modulator: mono/stereo audio to I/Q for the transmit chain.
// AM puts a DC-offset envelope on I, NBFM runs pre-emphasis, a phase
// accumulator and an iterative CORDIC rotation, RAW passes L/R straight to I/Q.
// The mode select is named mod_type because `type` is a reserved word.
//
// state   | meaning
// --------+---------------------------------------------------------------
// s_idle  | waiting for a strobe; AM/RAW samples are served from here
// s_pre   | pre-emphasis, phase accumulate, quadrant pre-rotation
// s_rot   | iters CORDIC micro-rotations, one per cycle
// s_out   | load saturated x/y into i_out/q_out
module mods #(
  parameter int dsz       = 16,
  parameter int fm_shift  = 3,
  parameter int cordic_x0 = 18903,
  parameter int iters     = 14
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic signed [dsz-1:0] l_in,
  input  logic signed [dsz-1:0] r_in,
  input  logic                  ena,
  input  logic [2:0]            mod_type,
  output logic                  busy,
  output logic                  valid,
  output logic signed [dsz-1:0] i_out,
  output logic signed [dsz-1:0] q_out
);

  localparam int xw = dsz + 2;
  localparam int zw = dsz + 1;
  localparam int ww = dsz + 4;
  localparam int cw = (iters > 1) ? $clog2(iters) : 1;

  localparam logic [2:0] type_am = 3'd0;
  localparam logic [2:0] type_fm = 3'd2;

  localparam logic signed [ww-1:0]  max_w  = ww'(2**(dsz-1) - 1);
  localparam logic signed [ww-1:0]  min_w  = ww'(-(2**(dsz-1)));
  localparam logic signed [dsz:0]   am_ofs = (dsz+1)'(2**(dsz-2));
  localparam logic signed [xw-1:0]  x0_c   = xw'(cordic_x0);

  typedef enum logic [1:0] {s_idle, s_pre, s_rot, s_out} state_t;

  state_t state, state_nxt;

  logic                  accept;
  logic                  ld_plain, ld_fm, do_pre, do_rot, do_out, busy_nxt;
  logic signed [dsz:0]   sum_lr;
  logic signed [dsz-1:0] mono;
  logic signed [dsz:0]   am_sum;
  logic signed [dsz-1:0] m_d1, m_cap, m_prev;
  logic signed [ww-1:0]  pe_raw;
  logic signed [dsz-1:0] pe, inc;
  logic [dsz-1:0]        phase, phase_nxt;
  logic signed [xw-1:0]  x, y, x_pre, y_pre, dx, dy;
  logic signed [zw-1:0]  z, z_pre, da;
  logic [cw-1:0]         iter;

  function automatic logic signed [dsz-1:0] sat_d(input logic signed [ww-1:0] v);
    if (v > max_w)      sat_d = max_w[dsz-1:0];
    else if (v < min_w) sat_d = min_w[dsz-1:0];
    else                sat_d = v[dsz-1:0];
  endfunction

  // Round-half-up arithmetic shift keeps the CORDIC error zero-mean.
  function automatic logic signed [xw-1:0] rnd_shr(input logic signed [xw-1:0] v,
                                                   input logic [cw-1:0] k);
    logic signed [xw-1:0] half;
    half    = (xw'(1) << k) >> 1;
    rnd_shr = (v + half) >>> k;
  endfunction

  // atan(2^-k) in phase units, 2^dsz units per turn (values for dsz = 16).
  function automatic logic signed [zw-1:0] atan_rom(input logic [cw-1:0] k);
    case (int'(k))
      0:       atan_rom = zw'(8192);
      1:       atan_rom = zw'(4836);
      2:       atan_rom = zw'(2555);
      3:       atan_rom = zw'(1297);
      4:       atan_rom = zw'(651);
      5:       atan_rom = zw'(326);
      6:       atan_rom = zw'(163);
      7:       atan_rom = zw'(81);
      8:       atan_rom = zw'(41);
      9:       atan_rom = zw'(20);
      10:      atan_rom = zw'(10);
      11:      atan_rom = zw'(5);
      12:      atan_rom = zw'(3);
      13:      atan_rom = zw'(1);
      14:      atan_rom = zw'(1);
      default: atan_rom = '0;
    endcase
  endfunction

  assign accept = ena & ~busy;
  assign sum_lr = (dsz+1)'(l_in) + (dsz+1)'(r_in);
  assign mono   = dsz'(sum_lr >>> 1);
  assign am_sum = ((dsz+1)'(mono) >>> 1) + am_ofs;

  assign pe_raw    = ww'(m_cap) + ((ww'(m_cap) - ww'(m_prev)) <<< 2);
  assign pe        = sat_d(pe_raw);
  assign inc       = pe >>> fm_shift;
  assign phase_nxt = phase + inc;
  // After removing the quadrant, the residual angle is just the low bits of
  // the phase, always in [0, 90 deg).
  assign z_pre     = zw'(phase_nxt[dsz-3:0]);

  assign dx = rnd_shr(y, iter);
  assign dy = rnd_shr(x, iter);
  assign da = atan_rom(iter);

  // Quadrant pre-rotation so the CORDIC only has to cover 0..90 degrees.
  always_comb begin
    x_pre = x0_c;
    y_pre = '0;
    case (phase_nxt[dsz-1:dsz-2])
      2'b01:   begin x_pre = '0;    y_pre = x0_c;  end
      2'b10:   begin x_pre = -x0_c; y_pre = '0;    end
      2'b11:   begin x_pre = '0;    y_pre = -x0_c; end
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= s_idle;
    else          state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      s_idle:  if (accept && mod_type == type_fm) state_nxt = s_pre;
      s_pre:   state_nxt = s_rot;
      s_rot:   if (iter == cw'(iters - 1)) state_nxt = s_out;
      s_out:   state_nxt = s_idle;
      default: state_nxt = s_idle;
    endcase
  end

  // FSM output decode; busy covers the output cycle so valid never repeats.
  always_comb begin
    ld_plain = accept && (mod_type != type_fm);
    ld_fm    = accept && (mod_type == type_fm);
    do_pre   = (state == s_pre);
    do_rot   = (state == s_rot);
    do_out   = (state == s_out);
    busy_nxt = (state_nxt != s_idle) || (state == s_out);
  end

  // Sample history, phase accumulator and CORDIC datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_d1   <= '0;
      m_cap  <= '0;
      m_prev <= '0;
      phase  <= '0;
      x      <= '0;
      y      <= '0;
      z      <= '0;
      iter   <= '0;
    end else begin
      if (accept) m_d1 <= mono;
      if (ld_fm) begin
        m_cap  <= mono;
        m_prev <= m_d1;
      end
      if (do_pre) begin
        phase <= phase_nxt;
        x     <= x_pre;
        y     <= y_pre;
        z     <= z_pre;
        iter  <= '0;
      end else if (do_rot) begin
        if (!z[zw-1]) begin
          x <= x - dx;
          y <= y + dy;
          z <= z - da;
        end else begin
          x <= x + dx;
          y <= y - dy;
          z <= z + da;
        end
        iter <= iter + cw'(1);
      end
    end
  end

  // Registered outputs and busy flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_out <= '0;
      q_out <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      valid <= ld_plain | do_out;
      busy  <= busy_nxt;
      if (ld_plain) begin
        if (mod_type == type_am) begin
          i_out <= sat_d(ww'(am_sum));
          q_out <= '0;
        end else begin
          i_out <= l_in;
          q_out <= r_in;
        end
      end else if (do_out) begin
        i_out <= sat_d(ww'(x));
        q_out <= sat_d(ww'(y));
      end
    end
  end

endmodule

// File: tb/tb_mods.sv
// Self-checking bench for mods: directed cases plus randomized strobes,
// compared against an arithmetic model of the modulator.
module tb_mods;

  localparam int  FM_LAT = 17;
  localparam int  FM_AMP = 31128;
  localparam real PI     = 3.14159265358979;

  logic               clk      = 1'b0;
  logic               reset_n  = 1'b0;
  logic signed [15:0] l_in     = '0;
  logic signed [15:0] r_in     = '0;
  logic               ena      = 1'b0;
  logic [2:0]         mod_type = '0;
  logic               busy, valid;
  logic signed [15:0] i_out, q_out;

  int n_vec = 0;
  int n_err = 0;
  int ref_hist  = 0;
  int ref_phase = 0;
  int am_l[3] = '{0, 32767, -32768};

  mods dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .l_in     (l_in),
    .r_in     (r_in),
    .ena      (ena),
    .mod_type (mod_type),
    .busy     (busy),
    .valid    (valid),
    .i_out    (i_out),
    .q_out    (q_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp, input int tol = 0);
    int d;
    d = got - exp;
    if (d < 0) d = -d;
    n_vec++;
    if (d > tol) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic int fdiv(input int a, input int b);
    return (a >= 0) ? a / b : -((-a + b - 1) / b);
  endfunction

  function automatic int sat16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference for one accepted strobe; FM only advances the model phase.
  task automatic ref_step(input int l, input int r, input int t,
                          output int ei, output int eq);
    int m, pe;
    m  = fdiv(l + r, 2);
    ei = l;
    eq = r;
    if (t == 2) begin
      pe = sat16(m + 4 * (m - ref_hist));
      ref_phase = ((ref_phase + fdiv(pe, 8)) % 65536 + 65536) % 65536;
    end else if (t == 0) begin
      ei = sat16(fdiv(m, 2) + 16384);
      eq = 0;
    end
    ref_hist = m;
  endtask

  task automatic fm_check(input string tag, input int gi, input int gq);
    real ang_exp, ang_got, d, mag;
    ang_exp = real'(ref_phase) * 360.0 / 65536.0;
    ang_got = $atan2(real'(gq), real'(gi)) * 180.0 / PI;
    d = ang_got - ang_exp;
    while (d > 180.0)   d = d - 360.0;
    while (d <= -180.0) d = d + 360.0;
    mag = $sqrt(real'(gi) * real'(gi) + real'(gq) * real'(gq));
    chk({tag, "_ang_mdeg"}, $rtoi(d * 1000.0), 0, 100);
    chk({tag, "_mag"}, $rtoi(mag + 0.5), FM_AMP, 8);
  endtask

  task automatic run_plain(input int l, input int r, input int t, input string tag);
    int ei, eq;
    ref_step(l, r, t, ei, eq);
    l_in = 16'(l); r_in = 16'(r); mod_type = 3'(t); ena = 1'b1;
    @(negedge clk);
    ena = 1'b0;
    chk({tag, "_valid"}, int'(valid), 1);
    chk({tag, "_i"}, int'(i_out), ei);
    chk({tag, "_q"}, int'(q_out), eq);
    @(negedge clk);
    chk({tag, "_vdrop"}, int'(valid), 0);
  endtask

  // One NBFM sample, optionally with a second strobe at inj_lat that must be dropped.
  task automatic run_fm(input int l, input int r, input int inj_lat,
                        input int inj_l, input int inj_r, input int inj_t,
                        input string tag, output int gi, output int gq);
    int ei, eq, first, nv, nb;
    ref_step(l, r, 2, ei, eq);
    first = 0; nv = 0; nb = 0; gi = 0; gq = 0;
    l_in = 16'(l); r_in = 16'(r); mod_type = 3'd2; ena = 1'b1;
    for (int lat = 1; lat <= FM_LAT + 3; lat++) begin
      @(negedge clk);
      ena = 1'b0;
      if (busy) nb++;
      if (valid) begin
        nv++;
        if (first == 0) begin
          first = lat;
          gi = int'(i_out);
          gq = int'(q_out);
        end
      end
      if (lat == inj_lat) begin
        l_in = 16'(inj_l); r_in = 16'(inj_r); mod_type = 3'(inj_t); ena = 1'b1;
      end
    end
    ena = 1'b0;
    chk({tag, "_lat"}, first, FM_LAT);
    chk({tag, "_nvalid"}, nv, 1);
    chk({tag, "_busy_cyc"}, nb, FM_LAT);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    ref_hist = 0;
    ref_phase = 0;
    repeat (2) @(negedge clk);
    chk({tag, "_i"}, int'(i_out), 0);
    chk({tag, "_q"}, int'(q_out), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int gi, gq, pi, pq, nv, sel, t, l, r, inj;
    @(negedge clk);
    do_reset("rst");

    // RAW: defined code and an undefined code behave the same
    run_plain(16'h1234, -5, 6, "raw6");
    run_plain(16'h1234, -5, 5, "raw5");

    // AM back-to-back strobes, each output checked the following cycle
    pi = 0; pq = 0;
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) begin
        chk("am_b2b_valid", int'(valid), 1);
        chk("am_b2b_i", int'(i_out), pi);
        chk("am_b2b_q", int'(q_out), pq);
      end
      if (k < 3) begin
        ref_step(am_l[k], am_l[k], 0, pi, pq);
        l_in = 16'(am_l[k]); r_in = 16'(am_l[k]); mod_type = 3'd0; ena = 1'b1;
      end else begin
        ena = 1'b0;
      end
      @(negedge clk);
    end
    chk("am_b2b_vdrop", int'(valid), 0);

    // NBFM zero audio from reset
    do_reset("rst2");
    run_fm(0, 0, 0, 0, 0, 0, "fm0", gi, gq);
    chk("fm0_i", gi, FM_AMP, 4);
    chk("fm0_q", gq, 0, 4);

    // Constant tone: first step saturated pre-emphasis, then steady steps, wraps
    for (int k = 0; k < 64; k++) begin
      run_fm(8192, 8192, 0, 0, 0, 0, "tone", gi, gq);
      fm_check("tone", gi, gq);
    end

    // Strobe during a rotation is dropped, phase follows the first sample only
    run_fm(1000, 1000, 5, 16000, 16000, 2, "drop", gi, gq);
    fm_check("drop", gi, gq);
    run_fm(0, 0, 0, 0, 0, 0, "after_drop", gi, gq);
    fm_check("after_drop", gi, gq);

    // Reset in the middle of a rotation
    l_in = 16'(5000); r_in = 16'(5000); mod_type = 3'd2; ena = 1'b1;
    nv = 0;
    for (int lat = 1; lat <= 8; lat++) begin
      @(negedge clk);
      ena = 1'b0;
      if (valid) nv++;
    end
    reset_n = 1'b0;
    ref_hist = 0;
    ref_phase = 0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_i", int'(i_out), 0);
    chk("midrst_q", int'(q_out), 0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 3) reset_n = 1'b1;
      if (valid) nv++;
    end
    chk("midrst_nvalid", nv, 0);
    run_fm(0, 0, 0, 0, 0, 0, "post_rst", gi, gq);
    chk("post_rst_i", gi, FM_AMP, 4);
    chk("post_rst_q", gq, 0, 4);

    // Randomized mix of modes, audio and in-flight strobes
    for (int k = 0; k < 40; k++) begin
      sel = int'($urandom_range(0, 3));
      l = int'($signed(16'($urandom)));
      r = int'($signed(16'($urandom)));
      case (sel)
        0:       t = 0;
        1:       t = 2;
        2:       t = 6;
        default: begin
          t = int'($urandom_range(3, 7));
          if (t == 6) t = 1;
        end
      endcase
      if (t == 2) begin
        inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, FM_LAT)) : 0;
        run_fm(l, r, inj, int'($signed(16'($urandom))), int'($signed(16'($urandom))),
               int'($urandom_range(0, 7)), "rnd_fm", gi, gq);
        fm_check("rnd_fm", gi, gq);
      end else begin
        run_plain(l, r, t, "rnd_plain");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
